// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the full-compare target.
// Functions work on a 32-bit container; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

   localparam int unsigned max_ptr_width = 32;

   function automatic logic [max_ptr_width-1:0] bin2gray(input logic [max_ptr_width-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros in the container leave the low bits of the result unaffected.
   function automatic logic [max_ptr_width-1:0] gray2bin(input logic [max_ptr_width-1:0] g);
      logic [max_ptr_width-1:0] b;
      b[max_ptr_width-1] = g[max_ptr_width-1];
      for (int i = max_ptr_width - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Gray value the write pointer holds when exactly one lap ahead of the read pointer.
   function automatic logic [max_ptr_width-1:0] full_target(input logic [max_ptr_width-1:0] g,
                                                           input int unsigned width);
      return g ^ (max_ptr_width'(2'b11) << (width - 2));
   endfunction

endpackage

// File: rtl/write_pointer_full_if.sv
// Write-side FIFO control bus between the write client and the write-pointer/full block.
interface write_pointer_full_if #(
   parameter int unsigned address_size = 3
);
   logic                    write_increment;
   logic                    overflow_clear;
   logic [address_size:0]   read_pointer_async;
   logic                    write_enable;
   logic [address_size-1:0] write_address;
   logic [address_size:0]   write_pointer;
   logic                    write_full;
   logic                    write_almost_full;
   logic [address_size:0]   write_level;
   logic                    write_overflow;

   modport master (
      output write_increment, overflow_clear, read_pointer_async,
      input  write_enable, write_address, write_pointer, write_full,
             write_almost_full, write_level, write_overflow
   );

   modport slave (
      input  write_increment, overflow_clear, read_pointer_async,
      output write_enable, write_address, write_pointer, write_full,
             write_almost_full, write_level, write_overflow
   );
endinterface

// File: rtl/sync_read_to_write.sv
// Multi-flop synchroniser for a Gray pointer crossing into the local clock domain.
module sync_read_to_write #(
   parameter int unsigned width       = 4,
   parameter int unsigned sync_stages = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] data_async,
   output logic [width-1:0] data_sync
);

   logic [width-1:0] sync_q [sync_stages];
   logic [width-1:0] sync_d [sync_stages];

   always_comb begin
      sync_d[0] = data_async;
      for (int unsigned i = 1; i < sync_stages; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < sync_stages; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < sync_stages; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign data_sync = sync_q[sync_stages-1];

endmodule

// File: rtl/write_pointer_full.sv
// Write-domain half of the async FIFO: write pointers, full/almost-full/level status
// and a sticky overflow flag, judged against the synchronised read pointer.
module write_pointer_full
   import fifo_pkg::*;
#(
   parameter int unsigned address_size       = 3,
   parameter int unsigned almost_full_margin = 1,
   parameter int unsigned sync_stages        = 2
) (
   input  logic               write_clk,
   input  logic               write_reset,
   write_pointer_full_if.slave bus
);

   localparam int unsigned ptr_width = address_size + 1;
   localparam int unsigned depth     = 1 << address_size;

   logic [ptr_width-1:0] read_sync;
   logic [ptr_width-1:0] read_binary_sync;

   logic [ptr_width-1:0] write_binary_q, write_binary_d;
   logic [ptr_width-1:0] write_pointer_q, write_pointer_d;
   logic [ptr_width-1:0] write_level_q, write_level_d;
   logic                 write_full_q, write_full_d;
   logic                 write_almost_full_q, write_almost_full_d;
   logic                 write_overflow_q, write_overflow_d;
   logic                 write_enable;

   sync_read_to_write #(
      .width       (ptr_width),
      .sync_stages (sync_stages)
   ) u_sync (
      .clk        (write_clk),
      .rst        (write_reset),
      .data_async (bus.read_pointer_async),
      .data_sync  (read_sync)
   );

   // Next pointer, status and overflow; status is computed from the post-write pointer.
   always_comb begin
      write_enable        = bus.write_increment & ~write_full_q;
      write_binary_d      = write_binary_q + ptr_width'(write_enable);
      write_pointer_d     = ptr_width'(bin2gray(max_ptr_width'(write_binary_d)));
      read_binary_sync    = ptr_width'(gray2bin(max_ptr_width'(read_sync)));
      write_full_d        = (write_pointer_d ==
                             ptr_width'(full_target(max_ptr_width'(read_sync), ptr_width)));
      write_level_d       = write_binary_d - read_binary_sync;
      write_almost_full_d = (write_level_d >= ptr_width'(depth - almost_full_margin));
      write_overflow_d    = (bus.write_increment & write_full_q) |
                            (write_overflow_q & ~bus.overflow_clear);
   end

   always_ff @(posedge write_clk or posedge write_reset) begin
      if (write_reset) begin
         write_binary_q      <= '0;
         write_pointer_q     <= '0;
         write_level_q       <= '0;
         write_full_q        <= 1'b0;
         write_almost_full_q <= 1'b0;
         write_overflow_q    <= 1'b0;
      end else begin
         write_binary_q      <= write_binary_d;
         write_pointer_q     <= write_pointer_d;
         write_level_q       <= write_level_d;
         write_full_q        <= write_full_d;
         write_almost_full_q <= write_almost_full_d;
         write_overflow_q    <= write_overflow_d;
      end
   end

   assign bus.write_enable      = write_enable;
   assign bus.write_address     = write_binary_q[address_size-1:0];
   assign bus.write_pointer     = write_pointer_q;
   assign bus.write_full        = write_full_q;
   assign bus.write_almost_full = write_almost_full_q;
   assign bus.write_level       = write_level_q;
   assign bus.write_overflow    = write_overflow_q;

endmodule

// File: tb/tb_write_pointer_full.sv
// Directed bench for write_pointer_full (address_size=3, margin=1, sync_stages=2).
module tb_write_pointer_full;

   logic write_clk;
   logic write_reset;

   write_pointer_full_if #(.address_size(3)) bus ();

   write_pointer_full #(
      .address_size       (3),
      .almost_full_margin (1),
      .sync_stages        (2)
   ) dut (
      .write_clk   (write_clk),
      .write_reset (write_reset),
      .bus         (bus)
   );

   initial write_clk = 1'b0;
   always #5 write_clk = ~write_clk;

   typedef struct {
      logic       inc;
      logic       clr;
      logic [3:0] rd;
      logic       we;
      logic [2:0] addr;
      logic [3:0] ptr;
      logic       full;
      logic       afull;
      logic [3:0] level;
      logic       ovf;
   } vec_t;

   vec_t vecs [15];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic do_reset();
      @(negedge write_clk);
      bus.write_increment    = 1'b0;
      bus.overflow_clear     = 1'b0;
      bus.read_pointer_async = 4'b0000;
      write_reset = 1'b1;
      @(negedge write_clk);
      write_reset = 1'b0;
   endtask

   task automatic check_regs(input string tag, input logic [2:0] addr, input logic [3:0] ptr,
                             input logic full, input logic afull, input logic [3:0] level,
                             input logic ovf);
      check({tag, ".addr"},  32'(bus.write_address),     32'(addr));
      check({tag, ".ptr"},   32'(bus.write_pointer),     32'(ptr));
      check({tag, ".full"},  32'(bus.write_full),        32'(full));
      check({tag, ".afull"}, 32'(bus.write_almost_full), 32'(afull));
      check({tag, ".level"}, 32'(bus.write_level),       32'(level));
      check({tag, ".ovf"},   32'(bus.write_overflow),    32'(ovf));
   endtask

   initial begin
      //            inc   clr   rd       we    addr  ptr      full  afull level ovf
      vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b0, 4'd6, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
      // Writes while full are dropped and latch overflow.
      vecs[8]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
      // Read pointer moves to binary 2; status follows three edges later.
      vecs[12] = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd6, 1'b0};

      write_reset            = 1'b1;
      bus.write_increment    = 1'b0;
      bus.overflow_clear     = 1'b0;
      bus.read_pointer_async = 4'b0000;
      repeat (2) @(posedge write_clk);
      #1;
      check_regs("reset", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge write_clk);
      write_reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge write_clk);
         bus.write_increment    = vecs[i].inc;
         bus.overflow_clear     = vecs[i].clr;
         bus.read_pointer_async = vecs[i].rd;
         #1;
         check($sformatf("vec%0d.we", i), 32'(bus.write_enable), 32'(vecs[i].we));
         @(posedge write_clk);
         #1;
         check_regs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ptr, vecs[i].full,
                    vecs[i].afull, vecs[i].level, vecs[i].ovf);
      end

      // Wrap-around: read side keeps pace so the synchronised view trails by two.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge write_clk);
         bus.write_increment    = 1'b1;
         bus.read_pointer_async = gray4(4'(k));
         @(posedge write_clk);
         #1;
         check($sformatf("wrap%0d.addr", k), 32'(bus.write_address), 32'(k % 8));
         check($sformatf("wrap%0d.ptr", k),  32'(bus.write_pointer), 32'(gray4(4'(k))));
         check($sformatf("wrap%0d.msb", k),  32'(bus.write_pointer[3]), 32'((k >> 3) & 1));
         check($sformatf("wrap%0d.full", k), 32'(bus.write_full), 32'(0));
         check($sformatf("wrap%0d.level", k), 32'(bus.write_level), 32'((k < 2) ? k : 2));
      end

      // Set wins over clear in the same cycle.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge write_clk);
         bus.write_increment = 1'b1;
      end
      @(posedge write_clk);
      #1;
      check("fill.full", 32'(bus.write_full), 32'(1));
      @(negedge write_clk);
      bus.write_increment = 1'b1;
      bus.overflow_clear  = 1'b1;
      @(posedge write_clk);
      #1;
      check("setclr1.ovf", 32'(bus.write_overflow), 32'(1));
      @(posedge write_clk);
      #1;
      check("setclr2.ovf", 32'(bus.write_overflow), 32'(1));
      @(negedge write_clk);
      bus.write_increment = 1'b0;
      @(posedge write_clk);
      #1;
      check("clr.ovf", 32'(bus.write_overflow), 32'(0));
      @(negedge write_clk);
      bus.overflow_clear  = 1'b0;
      bus.write_increment = 1'b1;
      @(posedge write_clk);
      #1;
      check("reset_pre.ovf", 32'(bus.write_overflow), 32'(1));

      // Asynchronous reset between edges clears state without a clock.
      #2;
      bus.write_increment = 1'b0;
      write_reset = 1'b1;
      #1;
      check_regs("async_rst", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
      check("async_rst.we", 32'(bus.write_enable), 32'(0));
      @(negedge write_clk);
      write_reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
